// File: rtl/rr_valid_arbiter.sv
// rr_valid_arbiter
//   Round-robin N-to-1 arbiter feeding a single registered valid/ready stage.
//   One requester wins per cycle. Its payload and source index are captured
//   into the output register. Downstream sees a one-entry pipeline FIFO: a
//   drain and an accept in the same cycle both take effect.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   up_data     flattened payloads, port i at [i*DATA_W +: DATA_W]
//   up_valid    per-port request
//   up_ready    per-port accept, at most one bit high
//   down_data   registered payload
//   down_id     registered source index of down_data
//   down_valid  registered valid
//   down_ready  downstream accept
//   grant_cnt   (only with RR_VALID_ARBITER_GRANT_CNT_EN) per-port saturating
//               16-bit grant counters, port i at [i*16 +: 16]
//
// Optional feature macro: RR_VALID_ARBITER_GRANT_CNT_EN

module rr_valid_arbiter #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS*DATA_W-1:0]   up_data,
  input  logic [N_PORTS-1:0]          up_valid,
  output logic [N_PORTS-1:0]          up_ready,
  output logic [DATA_W-1:0]           down_data,
  output logic [ID_W-1:0]             down_id,
  output logic                        down_valid,
  input  logic                        down_ready
`ifdef RR_VALID_ARBITER_GRANT_CNT_EN
  ,
  output logic [N_PORTS*16-1:0]       grant_cnt
`endif
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              valid_q, valid_d;
  logic [ID_W-1:0]   last_gnt_q, last_gnt_d;

  logic              slot_free;
  logic              any_req;
  logic              accept;
  logic [ID_W-1:0]   winner;
  logic [DATA_W-1:0] sel_data;

  assign slot_free = ~valid_q | down_ready;
  assign any_req   = |up_valid;
  assign accept    = slot_free & any_req;

  // Scan starts one past the last grant and wraps, so the most recent
  // winner becomes lowest priority.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = ID_W'((int'(last_gnt_q) + k) % N_PORTS);
      if (!found && up_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (winner == ID_W'(i)) begin
        sel_data = up_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // rst_n gates the grant so no requester sees a handshake while the
  // output register is held in reset.
  always_comb begin
    up_ready = '0;
    if (accept && rst_n) begin
      up_ready[winner] = 1'b1;
    end
  end

  // Accept takes priority over drain: dequeue and enqueue in one cycle.
  always_comb begin
    data_d     = data_q;
    id_d       = id_q;
    valid_d    = valid_q;
    last_gnt_d = last_gnt_q;
    if (accept) begin
      data_d     = sel_data;
      id_d       = winner;
      valid_d    = 1'b1;
      last_gnt_d = winner;
    end else if (valid_q && down_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      id_q       <= '0;
      valid_q    <= 1'b0;
      last_gnt_q <= ID_W'(N_PORTS - 1);
    end else begin
      data_q     <= data_d;
      id_q       <= id_d;
      valid_q    <= valid_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign down_data  = data_q;
  assign down_id    = id_q;
  assign down_valid = valid_q;

`ifdef RR_VALID_ARBITER_GRANT_CNT_EN
  for (genvar g = 0; g < N_PORTS; g++) begin : g_cnt
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (accept && (winner == ID_W'(g)) && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign grant_cnt[g*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_rr_valid_arbiter.sv
// Testbench for rr_valid_arbiter (N_PORTS=4, DATA_W=8, ID_W=2).
module tb_rr_valid_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] up_data;
  logic [3:0]  up_valid;
  logic [3:0]  up_ready;
  logic [7:0]  down_data;
  logic [1:0]  down_id;
  logic        down_valid;
  logic        down_ready;
`ifdef RR_VALID_ARBITER_GRANT_CNT_EN
  logic [63:0] grant_cnt;
`endif

  rr_valid_arbiter #(.N_PORTS(4), .DATA_W(8), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .down_data  (down_data),
    .down_id    (down_id),
    .down_valid (down_valid),
    .down_ready (down_ready)
`ifdef RR_VALID_ARBITER_GRANT_CNT_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: output slot contents, priority pointer, grant totals.
  int          m_last;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [1:0]  m_id;
  int          m_cnt [4];

  function automatic int model_winner(logic [3:0] v, int last);
    for (int p = last + 1; p < 4; p++) if (v[p]) return p;
    for (int p = 0; p <= last; p++) if (v[p]) return p;
    return -1;
  endfunction

  function automatic logic [3:0] model_ready(logic [3:0] v, logic r);
    int w;
    if (!rst_n) return 4'b0000;
    if (m_valid && !r) return 4'b0000;
    w = model_winner(v, m_last);
    if (w < 0) return 4'b0000;
    return 4'(1 << w);
  endfunction

  task automatic model_reset();
    m_last  = 3;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_id    = 2'd0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Apply one cycle of inputs; return observed and model up_ready, then
  // advance the model and the clock. Ends at posedge+1.
  task automatic tick(input logic [3:0] v, input logic [31:0] d, input logic r,
                      output logic [3:0] ur_obs, output logic [3:0] ur_exp);
    int w;
    up_valid   = v;
    up_data    = d;
    down_ready = r;
    #1;
    ur_obs = up_ready;
    ur_exp = model_ready(v, r);
    if (ur_exp != 4'b0000) begin
      w       = model_winner(v, m_last);
      m_data  = d[w*8 +: 8];
      m_id    = 2'(w);
      m_valid = 1'b1;
      m_last  = w;
      if (m_cnt[w] < 65535) m_cnt[w]++;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    up_valid   = 4'b0000;
    up_data    = '0;
    down_ready = 1'b1;
    rst_n      = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    up_valid   = 4'b1111;
    up_data    = 32'h13121110;
    down_ready = 1'b1;
    rst_n      = 1'b0;
    model_reset();
    #7;
    n_checks++;
    if (down_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", down_valid);
    else n_pass++;
    n_checks++;
    if (down_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", down_data);
    else n_pass++;
    n_checks++;
    if (down_id !== 2'd0) $display("FAIL reset_id: got %0d expected 0", down_id);
    else n_pass++;
    n_checks++;
    if (up_ready !== 4'b0000) $display("FAIL reset_up_ready: got %b expected 0000", up_ready);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_rotation();
    logic [3:0] uo, ue;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick(4'b1111, 32'h13121110, 1'b1, uo, ue);
      n_checks++;
      if (uo !== 4'(1 << (k % 4))) $display("FAIL rot_up_ready[%0d]: got %b expected %b", k, uo, 4'(1 << (k % 4)));
      else n_pass++;
      n_checks++;
      if (down_valid !== 1'b1 || down_id !== 2'(k % 4) || down_data !== 8'(8'h10 + k % 4))
        $display("FAIL rot_out[%0d]: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                 k, down_valid, down_id, down_data, k % 4, 8'(8'h10 + k % 4));
      else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [3:0] uo, ue;
    for (int k = 0; k < 4; k++) begin
      tick(4'b0100, 32'h00A50000, 1'b1, uo, ue);
      n_checks++;
      if (uo !== 4'b0100) $display("FAIL single_up_ready[%0d]: got %b expected 0100", k, uo);
      else n_pass++;
      n_checks++;
      if (down_valid !== 1'b1 || down_id !== 2'd2 || down_data !== 8'hA5)
        $display("FAIL single_out[%0d]: got v=%b id=%0d d=%h expected v=1 id=2 d=a5",
                 k, down_valid, down_id, down_data);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [3:0] uo, ue;
    do_reset();
    tick(4'b1001, 32'hD3C2B1A0, 1'b1, uo, ue);
    n_checks++;
    if (uo !== 4'b0001 || down_id !== 2'd0 || down_data !== 8'hA0)
      $display("FAIL stall_first: got ur=%b id=%0d d=%h expected ur=0001 id=0 d=a0", uo, down_id, down_data);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick(4'b1001, 32'hD3C2B1A0, 1'b0, uo, ue);
      n_checks++;
      if (uo !== 4'b0000 || down_valid !== 1'b1 || down_id !== 2'd0 || down_data !== 8'hA0)
        $display("FAIL stall_hold[%0d]: got ur=%b v=%b id=%0d d=%h expected ur=0000 v=1 id=0 d=a0",
                 k, uo, down_valid, down_id, down_data);
      else n_pass++;
    end
    tick(4'b1001, 32'hD3C2B1A0, 1'b1, uo, ue);
    n_checks++;
    if (uo !== 4'b1000 || down_valid !== 1'b1 || down_id !== 2'd3 || down_data !== 8'hD3)
      $display("FAIL stall_release: got ur=%b v=%b id=%0d d=%h expected ur=1000 v=1 id=3 d=d3",
               uo, down_valid, down_id, down_data);
    else n_pass++;
  endtask

  task automatic test_drain();
    logic [3:0] uo, ue;
    tick(4'b0000, 32'hFFFFFFFF, 1'b1, uo, ue);
    n_checks++;
    if (uo !== 4'b0000 || down_valid !== 1'b0 || down_id !== 2'd3 || down_data !== 8'hD3)
      $display("FAIL drain: got ur=%b v=%b id=%0d d=%h expected ur=0000 v=0 id=3 d=d3",
               uo, down_valid, down_id, down_data);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [3:0] uo, ue;
    do_reset();
    tick(4'b1111, 32'h13121110, 1'b1, uo, ue);
    tick(4'b1111, 32'h13121110, 1'b1, uo, ue);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (down_valid !== 1'b0 || up_ready !== 4'b0000)
      $display("FAIL async_reset: got v=%b ur=%b expected v=0 ur=0000", down_valid, up_ready);
    else n_pass++;
    model_reset();
    up_valid = 4'b0000;
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick(4'b1111, 32'h13121110, 1'b1, uo, ue);
    n_checks++;
    if (uo !== 4'b0001 || down_valid !== 1'b1 || down_id !== 2'd0 || down_data !== 8'h10)
      $display("FAIL async_reset_first: got ur=%b v=%b id=%0d d=%h expected ur=0001 v=1 id=0 d=10",
               uo, down_valid, down_id, down_data);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0]  uo, ue, v;
    logic [31:0] d;
    logic        r;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      v = 4'($urandom_range(0, 15));
      d = $urandom;
      r = ($urandom_range(0, 9) < 7);
      tick(v, d, r, uo, ue);
      n_checks++;
      if (uo !== ue) $display("FAIL rand_up_ready[%0d]: got %b expected %b", k, uo, ue);
      else n_pass++;
      n_checks++;
      if (down_valid !== m_valid || down_id !== m_id || down_data !== m_data)
        $display("FAIL rand_out[%0d]: got v=%b id=%0d d=%h expected v=%b id=%0d d=%h",
                 k, down_valid, down_id, down_data, m_valid, m_id, m_data);
      else n_pass++;
    end
  endtask

`ifdef RR_VALID_ARBITER_GRANT_CNT_EN
  task automatic test_grant_cnt();
    logic [3:0] uo, ue;
    do_reset();
    for (int k = 0; k < 6; k++) tick(4'b1111, 32'h13121110, 1'b1, uo, ue);
    n_checks++;
    if (grant_cnt !== {16'd1, 16'd1, 16'd2, 16'd2})
      $display("FAIL grant_cnt_rot: got %h expected 0001000100020002", grant_cnt);
    else n_pass++;
    do_reset();
    for (int k = 0; k < 70000; k++) tick(4'b0001, 32'h000000AA, 1'b1, uo, ue);
    n_checks++;
    if (grant_cnt[15:0] !== 16'hFFFF || m_cnt[0] != 65535)
      $display("FAIL grant_cnt_sat: got %h expected ffff", grant_cnt[15:0]);
    else n_pass++;
    n_checks++;
    if (grant_cnt[63:16] !== 48'd0)
      $display("FAIL grant_cnt_others: got %h expected 0", grant_cnt[63:16]);
    else n_pass++;
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    up_valid   = 4'b0000;
    up_data    = '0;
    down_ready = 1'b0;
    model_reset();
    test_reset();
    test_rotation();
    test_single();
    test_stall();
    test_drain();
    test_async_reset();
    test_random();
`ifdef RR_VALID_ARBITER_GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_valid_arbiter.md
Name: rr_valid_arbiter

Overview:
- N-to-1 round-robin arbiter that shares one registered valid/ready pipeline stage between N_PORTS upstream requesters.
- Each requester presents a valid/ready/data channel. The arbiter picks one winner per cycle and captures its data and source index into the output register.
- It presents them downstream with the same pipeline-FIFO semantics as a single-entry register slice.
- Sits in front of any shared single-channel consumer, such as a bus, memory port or shared processing stage.

Parameters:
- N_PORTS, 4, number of upstream requesters (2..16).
- DATA_W, 8, payload width per port.
- ID_W, 2, width of the source index; must equal clog2(N_PORTS).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- up_data  input  N_PORTS*DATA_W  flattened payloads; port i occupies bits [i*DATA_W +: DATA_W].
- up_valid  input  N_PORTS  per-port request/valid.
- up_ready  output  N_PORTS  per-port accept; at most one bit high per cycle.
- down_data  output  DATA_W  registered payload.
- down_id  output  ID_W  registered index of the port that supplied down_data.
- down_valid  output  1  registered valid.
- down_ready  input  1  downstream accept.

Behaviour:
- Reset (async, rst_n low):
  - down_valid=0, down_data=0, down_id=0.
  - RR pointer last_gnt=N_PORTS-1, so port 0 has highest priority after reset.
  - up_ready is all 0 for as long as rst_n is low.
- slot_free = ~down_valid | down_ready (combinational).
- Winner selection (combinational): scan up_valid starting at index last_gnt+1, wrapping modulo N_PORTS. The winner is the first index with up_valid set.
- up_ready[i] = slot_free & any(up_valid) & (winner==i). All other bits are 0.
- up_ready depends combinationally on up_valid and down_ready. There is no path from up_ready back to up_valid inside this block.
- Upstream rule: a requester must hold valid and data stable until it sees its own up_ready. The arbiter does not check this.
- Accept (slot_free & any(up_valid)), on the next edge:
  - down_data <= up_data[winner]
  - down_id <= winner
  - down_valid <= 1
  - last_gnt <= winner
- Drain only (down_valid & down_ready & no request): down_valid <= 0. down_data and down_id hold their last values.
- Simultaneous drain and accept: the accept wins. down_valid stays 1 and new data appears the next cycle. This is pipeline-FIFO ordering: dequeue, then enqueue in the same cycle.
- Stall (down_valid & ~down_ready): up_ready is all 0, and the output register and last_gnt are unchanged.
- last_gnt changes only on an accept. Idle cycles and stalls do not rotate priority.
- Latency: 1 cycle from up handshake to down_valid.
- Throughput: 1 transfer/cycle while down_ready=1.
- Fairness: a requester with valid held waits at most N_PORTS-1 grants.
- Single requester: served every cycle, with no bubbles.
- Wrap-around: when last_gnt=N_PORTS-1, the scan starts at 0.

Optional Feature:
- Macro: RR_VALID_ARBITER_GRANT_CNT_EN.
- When defined, an extra output grant_cnt (N_PORTS*16 bits) is added. Port i's counter occupies bits [i*16 +: 16].
  - Each counter resets to 0 asynchronously.
  - It increments on every accept where winner==i.
  - It saturates at 16'hFFFF and does not wrap.
- When not defined, the grant_cnt port and the counters are absent. Arbitration behaviour is identical either way.

Test Plan:
- Reset then all four up_valid=1, down_ready=1, up_data=8'h10,11,12,13:
  - down_id sequence is 0,1,2,3,0,... on consecutive cycles.
  - down_valid stays high from cycle 1 with no bubbles.
- Only port 2 valid with data 8'hA5, down_ready=1:
  - up_ready=4'b0100 every cycle.
  - down_data=8'hA5 and down_id=2 one cycle later.
  - Priority does not skip port 2.
- Ports 0 and 3 valid, down_ready=0 after the first accept:
  - up_ready=0 during the stall, and down_data/down_id hold the port 0 entry.
  - When down_ready=1, the same cycle accepts port 3 and down_id becomes 3 on the next edge.
- Drain without a new request (valid entry, down_ready=1, up_valid=0):
  - down_valid falls to 0 next cycle.
  - down_data and down_id keep their last value.
- Assert rst_n=0 mid-burst, asynchronously between edges:
  - down_valid goes to 0 immediately.
  - After release, with all ports valid, the first grant is port 0.
- With RR_VALID_ARBITER_GRANT_CNT_EN, after 6 grants in the all-valid rotation: grant_cnt = {1,1,2,2} for ports {3,2,1,0}.
- With RR_VALID_ARBITER_GRANT_CNT_EN, force port 0 alone for 70000 accepts: counter 0 stays at 16'hFFFF.
